// File: rtl/serial_parity_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_rx_pkg
//  Description : Shared types and constants for the serial parity receiver
//                and its companion transmitter.
//                - rx_state_e  : 2-bit receiver frame state
//                - PARITY_EVEN / PARITY_ODD : parity-sense selectors
//                - cnt_width() : width of the data-bit counter (minimum 1)
//  Revision    : 1.0  initial release
// ============================================================================
package serial_parity_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    // A single-bit word still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_parity_rx_parity_acc.sv
`default_nettype none
// ============================================================================
//  Module      : xor2 / parity_acc
//  Description : xor2      - two-input XOR gate.
//                parity_acc - 1-bit running XOR accumulator with synchronous
//                clear and enable.
//  Ports (parity_acc):
//                clk_i   - rising-edge clock
//                reset_i - asynchronous active-high reset
//                clr_i   - clear accumulator (wins over enable)
//                en_i    - fold d_i into the accumulator
//                d_i     - data bit
//                acc_o   - accumulated XOR value
//  Revision    : 1.0  initial release
// ============================================================================
module xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module parity_acc (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic d_i,
    output logic acc_o
);
    logic acc_q;
    logic acc_d;

    xor2 u_xor2 (
        .a_i (acc_q),
        .b_i (d_i),
        .y_o (acc_d)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule
`default_nettype wire

// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_rx
//  Description : Bit-serial frame receiver: start(0), DATA_W data bits LSB
//                first, parity bit, stop(1). The line is sampled once per
//                bit_en_i strobe. Flags parity and framing errors.
//  Ports:
//                clk_i        - rising-edge clock
//                reset_i      - asynchronous active-high reset
//                bit_en_i     - one-cycle bit-time strobe
//                rx_i         - serial line, idle high
//                data_out_o   - last good word, LSB = first data bit
//                data_valid_o - one-cycle pulse: frame with good stop bit
//                parity_err_o - parity mismatch, qualified by data_valid_o
//                frame_err_o  - one-cycle pulse: stop bit sampled low
//                busy_o       - high while a frame is in progress
//  Revision    : 1.0  initial release
// ============================================================================
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit ODD    = PARITY_EVEN
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              bit_en_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              data_valid_o,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              busy_o
);
    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              perr_r_q;
    logic              ferr_q;
    logic              busy_q;

    logic              w_acc;
    logic              w_acc_clr;
    logic              w_acc_en;

    // Accumulator restarts on the start bit and folds in every data bit.
    assign w_acc_clr = bit_en_i && (state_q == IDLE) && !rx_i;
    assign w_acc_en  = bit_en_i && (state_q == DATA);

    parity_acc u_parity_acc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (w_acc_clr),
        .en_i    (w_acc_en),
        .d_i     (rx_i),
        .acc_o   (w_acc)
    );

    // Right shift with new bit entering at the MSB: after DATA_W samples the
    // first bit received sits in bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_w1
            assign shift_d = rx_i;
        end else begin : g_shift_wn
            assign shift_d = {rx_i, shift_q[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            perr_r_q <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Flags are single-cycle pulses regardless of bit_en.
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (bit_en_i) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_i) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        perr_r_q <= w_acc ^ rx_i ^ ODD;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (rx_i) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            perr_q  <= perr_r_q;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_parity_rx
//  Description : Self-checking bench for serial_parity_rx. Two 8-bit
//                receivers (even and odd parity) share one serial line; a
//                third 1-bit receiver has its own line.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_en;
    logic       rx;
    logic       bit_en1;
    logic       rx1;

    logic [7:0] e_dout, o_dout;
    logic       e_valid, o_valid, e_perr, o_perr, e_ferr, o_ferr, e_busy, o_busy;
    logic [0:0] w_dout;
    logic       w_valid, w_perr, w_ferr, w_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .ODD(1'b0)) dut_even (
        .clk_i(clk), .reset_i(reset), .bit_en_i(bit_en), .rx_i(rx),
        .data_out_o(e_dout), .data_valid_o(e_valid), .parity_err_o(e_perr),
        .frame_err_o(e_ferr), .busy_o(e_busy)
    );

    serial_parity_rx #(.DATA_W(8), .ODD(1'b1)) dut_odd (
        .clk_i(clk), .reset_i(reset), .bit_en_i(bit_en), .rx_i(rx),
        .data_out_o(o_dout), .data_valid_o(o_valid), .parity_err_o(o_perr),
        .frame_err_o(o_ferr), .busy_o(o_busy)
    );

    serial_parity_rx #(.DATA_W(1), .ODD(1'b0)) dut_w1 (
        .clk_i(clk), .reset_i(reset), .bit_en_i(bit_en1), .rx_i(rx1),
        .data_out_o(w_dout), .data_valid_o(w_valid), .parity_err_o(w_perr),
        .frame_err_o(w_ferr), .busy_o(w_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr_e;
        logic       exp_perr_o;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bit on the shared line; returns at the negedge after the
    // sampling edge so registered results are visible.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) @(negedge clk);
        rx     = b;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    task automatic send_bit1(input logic b);
        repeat (2) @(negedge clk);
        rx1     = b;
        bit_en1 = 1'b1;
        @(negedge clk);
        bit_en1 = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
        send_bit(1'b0, gap);
        check("busy_after_start_e", e_busy, 1);
        check("busy_after_start_o", o_busy, 1);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        check("no_valid_before_stop", e_valid, 0);
        send_bit(s, gap);
    endtask

    task automatic check_frame(input string tag, input logic v, input logic f,
                               input logic pe, input logic po, input logic [7:0] dout);
        check({tag, "_valid_e"}, e_valid, v);
        check({tag, "_valid_o"}, o_valid, v);
        check({tag, "_ferr_e"},  e_ferr,  f);
        check({tag, "_ferr_o"},  o_ferr,  f);
        check({tag, "_perr_e"},  e_perr,  pe);
        check({tag, "_perr_o"},  o_perr,  po);
        check({tag, "_dout_e"},  e_dout,  dout);
        check({tag, "_dout_o"},  o_dout,  dout);
        check({tag, "_busy_e"},  e_busy,  0);
        check({tag, "_busy_o"},  o_busy,  0);
        // One cycle later every flag must be gone.
        @(negedge clk);
        check({tag, "_pulse_end_e"}, {e_valid, e_ferr, e_perr}, 0);
        check({tag, "_pulse_end_o"}, {o_valid, o_ferr, o_perr}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_e"}, {e_dout, e_valid, e_perr, e_ferr, e_busy}, 0);
        check({tag, "_o"}, {o_dout, o_valid, o_perr, o_ferr, o_busy}, 0);
        check({tag, "_w"}, {w_dout, w_valid, w_perr, w_ferr, w_busy}, 0);
    endtask

    // Abort 0xFF after four data bits with an asynchronous reset.
    task automatic mid_frame_reset();
        send_bit(1'b0, 3);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 3);
        check("busy_mid_frame", e_busy, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset_idle");
    endtask

    initial begin
        logic [7:0] last_good;
        logic [7:0] d;
        logic       p, s, v, f, pe, po;

        // data  p  s  valid ferr perr_e perr_o dout
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[3] = '{8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[5] = '{8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03};
        vecs[6] = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
        vecs[7] = '{8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA};

        reset   = 1'b1;
        bit_en  = 1'b0;
        rx      = 1'b1;
        bit_en1 = 1'b0;
        rx1     = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Idle line with strobes must not start a frame.
        send_bit(1'b1, 1);
        check("idle_no_busy", e_busy, 0);

        for (int i = 0; i < 8; i++) begin
            if (i == 3) mid_frame_reset();
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit,
                       (i >= 6) ? int'($urandom_range(0, 3)) : 3);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ferr,
                        vecs[i].exp_perr_e, vecs[i].exp_perr_o, vecs[i].exp_dout);
        end

        // Single-bit word: DATA lasts one sample.
        send_bit1(1'b0); send_bit1(1'b1); send_bit1(1'b1); send_bit1(1'b1);
        check("w1_valid", w_valid, 1);
        check("w1_dout",  w_dout,  1);
        check("w1_perr",  w_perr,  0);
        check("w1_busy",  w_busy,  0);
        send_bit1(1'b0); send_bit1(1'b1); send_bit1(1'b0); send_bit1(1'b1);
        check("w1_valid2", w_valid, 1);
        check("w1_perr2",  w_perr,  1);
        send_bit1(1'b0); send_bit1(1'b0); send_bit1(1'b0); send_bit1(1'b0);
        check("w1_ferr",   w_ferr,  1);
        check("w1_dout3",  w_dout,  1);

        // Randomized frames against a frame-level model.
        last_good = 8'hAA;
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            s  = ($urandom_range(0, 4) != 0);
            v  = s;
            f  = !s;
            pe = s & ((^d) ^ p);
            po = s & ((^d) ^ p ^ 1'b1);
            if (s) last_good = d;
            send_frame(d, p, s, int'($urandom_range(0, 3)));
            check_frame($sformatf("rnd%0d", n), v, f, pe, po, last_good);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Bit-serial frame receiver with parity check.
- Pairs with the team's parity-generating serial transmitter. It deserialises start/data/parity/stop frames, recomputes parity with an XOR accumulator and flags parity and framing errors.
- Sits after the bit-rate strobe generator.
- Samples the line once per asserted bit_en; there is no oversampling.

Parameters:
- DATA_W, 8, data bits per frame; legal range 1..16.
- ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- bit_en  input  1  one-cycle bit-time strobe; the line is sampled only when this is high.
- rx  input  1  serial line, idle high.
- data_out  output  DATA_W  last received word, LSB = first data bit.
- data_valid  output  1  one-cycle pulse: frame complete with a good stop bit.
- parity_err  output  1  qualified by data_valid: 1 = parity mismatch.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, any time including mid-frame):
  - state = IDLE, data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - Bit counter and parity accumulator are cleared.
- Frame format: start (0), DATA_W data bits LSB first, parity bit, stop (1). One bit per bit_en.
- When bit_en = 0, all state holds. data_valid and frame_err still deassert after their single cycle.
- FSM transitions (all taken only on bit_en = 1):
  - IDLE: rx = 0 -> DATA; clear cnt and acc. rx = 1 -> stay in IDLE.
  - DATA: shift rx into shift register MSB with a right shift, so the first bit ends in bit 0; acc ^= rx; cnt++. When cnt == DATA_W-1 on this sample -> PARITY.
  - PARITY: perr_r = acc ^ rx ^ ODD -> STOP.
  - STOP, rx = 1:
    - data_out <= shift register; data_valid <= 1; parity_err <= perr_r -> IDLE.
    - The parity error is reported, not dropped.
  - STOP, rx = 0:
    - frame_err <= 1; data_valid = 0; parity_err = 0; data_out unchanged -> IDLE.
    - No resync: the next bit_en with rx = 0 starts a new frame.
- Latency: the flags rise at the clk edge that samples the stop bit and are high for exactly one cycle.
- data_out holds its value until the next good frame.
- parity_err is driven 0 whenever data_valid = 0.
- Back-to-back frames: a start bit on the bit_en directly after the stop bit is accepted. Zero idle bits are required.
- Widths:
  - cnt is $clog2(DATA_W) bits, minimum 1.
  - DATA_W = 1 goes DATA -> PARITY after a single sample.
- busy:
  - Rises on the edge that accepts the start bit.
  - Falls on the edge that samples the stop bit.

Decomposition:
- Shared package holds:
  - State enum: IDLE, DATA, PARITY, STOP (2-bit).
  - PARITY_EVEN = 0 and PARITY_ODD = 1 constants, shared with the transmitter.
- One sub-module, parity_acc:
  - 1-bit XOR accumulator with clear and enable, built on the team's xor2 gate.
  - Reused by the transmitter.
- FSM, shifter and counter stay in serial_parity_rx.

Test Plan:
1. DATA_W = 8, ODD = 0, bit_en every 4th cycle. Send 0xA5 (bits 1,0,1,0,0,1,0,1), parity 0, stop 1 -> data_valid pulse, data_out = 0xA5, parity_err = 0, busy low after the stop bit.
2. Same frame with parity bit 1 -> data_valid = 1, data_out = 0xA5, parity_err = 1.
3. Send 0x3C with stop bit 0 -> frame_err pulse, data_valid = 0, data_out keeps 0xA5.
4. Assert reset after the 4th data bit of 0xFF -> all outputs 0 immediately. Then a clean 0x12 frame -> data_out = 0x12, parity_err = 0.
5. ODD = 1, send 0x01 with parity 0 -> parity_err = 0. Then 0x03 with parity 0 -> parity_err = 1.
6. Two back-to-back frames 0x55 then 0xAA with irregular bit_en gaps and no idle bits -> two data_valid pulses, values 0x55 then 0xAA, no errors.
